// File: rtl/freq_meas.sv
// Gated-count frequency meter.
// Synchronises an asynchronous input and counts its rising edges over a fixed
// window of GATE_CYCLES clocks. The count is scaled to Hz and published with a
// one-cycle valid strobe.
// Optional feature macro: FREQ_MEAS_SAT_EN enables saturation of the result and
// of the edge counter, and drives o_ovf. When the macro is undefined, the result
// wraps modulo 2^28 and o_ovf is tied to 0.
module freq_meas #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned GATE_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_sig,
    input  logic        i_en,
    output logic [27:0] o_freq,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_ovf
);

    localparam int unsigned SCALE     = CLK_HZ / GATE_CYCLES;
    localparam logic [63:0] SCALE64   = 64'(SCALE);
    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StArm, StGate, StLatch} state_e;

    state_e      state_q;
    logic [1:0]  sync_q;
    logic        dly_q;
    logic        rise;
    logic [31:0] gate_cnt_q;
    logic [27:0] edge_cnt_q;
    logic [27:0] edge_cnt_d;
    logic [63:0] scaled;
    logic [27:0] res_freq;
    logic [27:0] freq_q;
    logic        valid_q;
    logic        busy_q;

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b00;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_sig};
            dly_q  <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~dly_q;

    // Full-width product so that the overflow test sees every bit.
    assign scaled = {36'd0, edge_cnt_q} * SCALE64;

`ifdef FREQ_MEAS_SAT_EN
    logic res_ovf;
    logic ovf_q;

    // Saturating edge counter and clamped result.
    always_comb begin
        edge_cnt_d = (edge_cnt_q == 28'hFFF_FFFF) ? edge_cnt_q : edge_cnt_q + 28'd1;
        res_ovf    = (scaled[63:28] != 36'd0) || (edge_cnt_q == 28'hFFF_FFFF);
        res_freq   = (scaled[63:28] != 36'd0) ? 28'hFFF_FFFF : scaled[27:0];
    end

    // Overflow flag updates only together with the result strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (state_q == StLatch) begin
            ovf_q <= res_ovf;
        end
    end

    assign o_ovf = ovf_q;
`else
    logic unused_hi;

    // Wrapping edge counter; the result is the product modulo 2^28.
    always_comb begin
        edge_cnt_d = edge_cnt_q + 28'd1;
        res_freq   = scaled[27:0];
        unused_hi  = ^scaled[63:28];
    end

    assign o_ovf = 1'b0;
`endif

    // Measurement FSM: arm, count over the gate, latch, then rearm or idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            gate_cnt_q <= 32'd0;
            edge_cnt_q <= 28'd0;
            freq_q     <= 28'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_en) begin
                        state_q <= StArm;
                        busy_q  <= 1'b1;
                    end
                end
                StArm: begin
                    if (!i_en) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gate_cnt_q <= 32'd0;
                        edge_cnt_q <= 28'd0;
                        state_q    <= StGate;
                    end
                end
                StGate: begin
                    if (!i_en) begin
                        // Abort: previous result and flag are left untouched.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 32'd1;
                        if (rise) begin
                            edge_cnt_q <= edge_cnt_d;
                        end
                        if (gate_cnt_q == GATE_LAST) begin
                            state_q <= StLatch;
                        end
                    end
                end
                StLatch: begin
                    freq_q  <= res_freq;
                    valid_q <= 1'b1;
                    if (i_en) begin
                        state_q <= StArm;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_freq  = freq_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_freq_meas.sv
// Testbench for freq_meas: a small-gate instance checked through a result
// scoreboard, plus a high-scale instance for the overflow behaviour.
module tb_freq_meas;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sig_a = 1'b0;
    logic        en_a = 1'b0;
    logic [27:0] freq_a;
    logic        valid_a;
    logic        busy_a;
    logic        ovf_a;
    logic        sig_b = 1'b0;
    logic        en_b = 1'b0;
    logic [27:0] freq_b;
    logic        valid_b;
    logic        busy_b;
    logic        ovf_b;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt = 0;
    int unsigned valid_cnt = 0;
    int unsigned per_a = 10;
    logic [28:0] exp_q[$];

    freq_meas #(.CLK_HZ(1000), .GATE_CYCLES(100)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_sig  (sig_a),
        .i_en   (en_a),
        .o_freq (freq_a),
        .o_valid(valid_a),
        .o_busy (busy_a),
        .o_ovf  (ovf_a)
    );

    freq_meas #(.CLK_HZ(1_000_000_000), .GATE_CYCLES(1000)) dut_hi (
        .clk    (clk),
        .rstn   (rstn),
        .i_sig  (sig_b),
        .i_en   (en_b),
        .o_freq (freq_b),
        .o_valid(valid_b),
        .o_busy (busy_b),
        .o_ovf  (ovf_b)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Counts falling edges until o_valid of instance A is seen (bounded).
    task automatic wait_valid_a(input int unsigned max, output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < max);
        chk("valid_a_seen", 32'(valid_a), 32'd1);
    endtask

    // Input stimulus for A: square wave of period per_a (0 = held low); B toggles every cycle.
    initial begin
        int unsigned ph;
        ph = 0;
        forever begin
            @(negedge clk);
            sig_b = ~sig_b;
            if (per_a == 0) begin
                sig_a = 1'b0;
            end else begin
                ph = (ph + 1 >= per_a) ? 0 : ph + 1;
                sig_a = (ph < per_a / 2);
            end
        end
    end

    // Scoreboard: every strobe from A must match the oldest queued expectation.
    initial forever begin
        @(negedge clk);
        if (valid_a) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                chk("sb_freq", 32'(freq_a), 32'(e[27:0]));
                chk("sb_ovf", 32'(ovf_a), 32'(e[28]));
            end
        end
    end

    initial begin
        int unsigned n;
        int unsigned vsnap;
        logic [27:0] exp_fb;
        logic        exp_ob;

        // Reset state and idle behaviour with the input toggling.
        #23;
        chk("rst_freq", 32'(freq_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovf_b", 32'(ovf_b), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        chk("idle_freq", 32'(freq_a), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_ovf", 32'(ovf_a), 32'd0);
        chk("idle_no_valid", valid_cnt, 32'd0);

        // Continuous mode, period 10: 10 edges x SCALE 10.
        exp_q.push_back({1'b0, 28'd100});
        exp_q.push_back({1'b0, 28'd100});
        en_a = 1'b1;
        @(negedge clk);
        chk("arm_busy", 32'(busy_a), 32'd1);
        wait_valid_a(300, n);
        chk("first_latency", n, 32'd102);
        wait_valid_a(300, n);
        chk("period_cont", n, 32'd102);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_busy", 32'(busy_a), 32'd0);

        // Input at CLK_HZ/2.
        per_a = 2;
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b0, 28'd500});
        en_a = 1'b1;
        wait_valid_a(300, n);
        en_a = 1'b0;

        // Static input still strobes, with zero frequency.
        per_a = 0;
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b0, 28'd0});
        en_a = 1'b1;
        wait_valid_a(300, n);
        en_a = 1'b0;

        // Back to 100 Hz so the abort test has a known prior value.
        per_a = 10;
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b0, 28'd100});
        en_a = 1'b1;
        wait_valid_a(300, n);
        en_a = 1'b0;
        repeat (5) @(negedge clk);

        // Abort mid-gate: no strobe, result held.
        en_a = 1'b1;
        repeat (52) @(negedge clk);
        en_a = 1'b0;
        vsnap = valid_cnt;
        repeat (150) @(negedge clk);
        chk("abort_no_valid", valid_cnt, vsnap);
        chk("abort_freq_hold", 32'(freq_a), 32'd100);
        chk("abort_busy", 32'(busy_a), 32'd0);

        // Re-enable gives a fresh full gate.
        exp_q.push_back({1'b0, 28'd100});
        en_a = 1'b1;
        @(negedge clk);
        wait_valid_a(300, n);
        chk("reenable_latency", n, 32'd102);
        en_a = 1'b0;
        repeat (3) @(negedge clk);

        // High-scale instance: 500 edges x 10^6 exceeds 28 bits.
`ifdef FREQ_MEAS_SAT_EN
        exp_fb = 28'hFFF_FFFF;
        exp_ob = 1'b1;
`else
        exp_fb = 28'd231_564_544;
        exp_ob = 1'b0;
`endif
        en_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_b && n < 1100);
        chk("hi_valid_seen", 32'(valid_b), 32'd1);
        chk("hi_freq", 32'(freq_b), 32'(exp_fb));
        chk("hi_ovf", 32'(ovf_b), 32'(exp_ob));
        en_b = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a gate.
        en_a = 1'b1;
        repeat (40) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_freq", 32'(freq_a), 32'd0);
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_idle", 32'(busy_a), 32'd0);
        exp_q.push_back({1'b0, 28'd100});
        @(negedge clk);
        chk("post_rst_arm", 32'(busy_a), 32'd1);
        wait_valid_a(300, n);
        chk("post_rst_latency", n, 32'd102);
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
